segled_serial_rx: RTL
=====================

Name: segled_serial_rx

Overview:
- Receive end of the 4-wire serial 7-segment link (SEGLED_CLK, SEGLED_DO, SEGLED_PEN, SEGLED_CLR) driven by the board's Seg7Device serializer.
- Oversamples the link on the system clock and deserializes 64-bit frames (8 digits x 8 segment bits).
- Latches complete frames and decodes each segment byte back into a hex nibble.
- Used as an on-chip loopback checker and as a display model in simulation benches.

Parameters:
- FRAME_BITS, 64, bits per frame; must be a multiple of 8.
- DIGITS, 8, FRAME_BITS/8; number of decoded digits.
- CNT_W, 7, width of the bit counter; must hold FRAME_BITS+1.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- seg_clk  input  1  serial shift clock (SEGLED_CLK), asynchronous to clk
- seg_do  input  1  serial data (SEGLED_DO), MSB first
- seg_pen  input  1  latch enable (SEGLED_PEN); low while shifting, rising edge latches
- seg_clr  input  1  active-low clear (SEGLED_CLR)
- seg_pattern  output  64  last latched raw frame
- digits  output  32  decoded nibbles; digit 7 in [31:28]
- digit_valid  output  8  bit i = 1 when byte i decodes to a legal hex glyph
- frame_valid  output  1  one-cycle pulse when a good frame is latched
- frame_err  output  1  sticky flag for a wrong bit count at latch; cleared by reset or seg_clr
- frame_count  output  16  count of good frames, wraps at 16'hFFFF

Behaviour:
- Reset (rstn=0, async) forces these values:
  - seg_pattern = all ones (blank), digits = 0, digit_valid = 0.
  - frame_valid = 0, frame_err = 0, frame_count = 0.
  - FSM returns to IDLE and the bit counter clears.
- Synchronization:
  - All four link inputs pass through 2-flop synchronizers.
  - Edges are detected on the synchronized signals, so an edge takes effect 3 clk after the pin change.
  - seg_clk high and low phases must each last >= 3 clk; the serializer's clk/16 IO clock satisfies this.
- Shift:
  - On each detected seg_clk rising edge while seg_pen_s = 0, the shift register becomes {shreg[62:0], seg_do_s}.
  - The bit counter increments, saturating at FRAME_BITS+1.
- FSM states:
  - IDLE: seg_pen_s high. Go to SHIFT when seg_pen_s falls; the counter clears on entry.
  - SHIFT: accept bits. Go to LATCH on a seg_pen_s rising edge.
  - LATCH: one cycle. If the count equals FRAME_BITS, load seg_pattern, go to DECODE, and increment frame_count. Otherwise set frame_err, leave outputs unchanged, and go to IDLE.
  - DECODE: one cycle. Register digits and digit_valid from the decoder, assert frame_valid for that cycle, then go to IDLE.
- Latency: frame_valid asserts 2 clk after the synchronized seg_pen rising edge. digits, digit_valid and seg_pattern are stable on and after that cycle.
- Segment encoding:
  - Byte i = seg_pattern[8i+7:8i] = {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
  - The dp bit is ignored for decode.
  - Legal glyphs for 0..F, as bits [6:0]: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
  - Any other pattern gives digit_valid[i] = 0 and nibble 0.
- seg_clr_s = 0 is a synchronous clear with priority over everything:
  - Shift register and counter clear; FSM goes to IDLE.
  - seg_pattern is blanked to all ones, digit_valid = 0, frame_err clears.
  - frame_count is unchanged.
- Boundary conditions:
  - seg_clr low together with a seg_pen rise: clear wins and no latch occurs.
  - More than 64 bits shifted: the count saturates at 65 and the frame errors at latch.
  - seg_clk edge in the same cycle as the seg_pen rise: the bit is shifted first, then the count is checked in LATCH.
  - seg_clk edges while in IDLE are ignored.
  - Reset mid-frame: partial data is discarded.

Decomposition:
- Shared package segled_pkg holds:
  - FRAME_BITS, state enum (IDLE/SHIFT/LATCH/DECODE), GLYPH constants 0..F.
- One sub-module, seg7_glyph_decode, combinational:
  - Input 7 bits; outputs nibble and valid.
  - Instantiated DIGITS times.

Test Plan:
- Reset then idle: outputs blank/zero, frame_count 0, no frame_valid pulse.
- 64 bits of repeated byte 8'hC0, then seg_pen rise: digits = 32'h00000000, digit_valid = 8'hFF, frame_valid pulses once, frame_count = 1.
- Frame with glyphs for 1,2,3,4,5,6,7,8 (digit 7 first: F9 A4 B0 99 92 82 F8 80): digits = 32'h12345678, digit_valid = 8'hFF.
- 63 bits then latch: frame_err = 1, seg_pattern unchanged, no frame_valid; the next good 64-bit frame latches and frame_err stays 1 until seg_clr.
- Byte 8'hFF at digit 3, others C0: digit_valid = 8'hF7, digits[15:12] = 0.
- seg_clr low mid-frame after 30 bits, then a full frame: the first partial frame is discarded, the second latches correctly, frame_err = 0.

Source files
------------

// File: rtl/segled_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segled_pkg                                                           |
// | Shared constants for the serial 7-segment receiver: frame geometry,  |
// | FSM state encoding and the active-low glyph set for 0..F.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package segled_pkg;

    localparam int c_FRAME_BITS = 64;
    localparam int c_DIGITS     = c_FRAME_BITS / 8;

    localparam int         c_ST_W      = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_LATCH  = 2'd2;
    localparam logic [1:0] c_ST_DECODE = 2'd3;

    // Segment bits {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [6:0] c_GLYPH_0 = 7'h40;
    localparam logic [6:0] c_GLYPH_1 = 7'h79;
    localparam logic [6:0] c_GLYPH_2 = 7'h24;
    localparam logic [6:0] c_GLYPH_3 = 7'h30;
    localparam logic [6:0] c_GLYPH_4 = 7'h19;
    localparam logic [6:0] c_GLYPH_5 = 7'h12;
    localparam logic [6:0] c_GLYPH_6 = 7'h02;
    localparam logic [6:0] c_GLYPH_7 = 7'h78;
    localparam logic [6:0] c_GLYPH_8 = 7'h00;
    localparam logic [6:0] c_GLYPH_9 = 7'h10;
    localparam logic [6:0] c_GLYPH_A = 7'h08;
    localparam logic [6:0] c_GLYPH_B = 7'h03;
    localparam logic [6:0] c_GLYPH_C = 7'h46;
    localparam logic [6:0] c_GLYPH_D = 7'h21;
    localparam logic [6:0] c_GLYPH_E = 7'h06;
    localparam logic [6:0] c_GLYPH_F = 7'h0E;

    function automatic logic [6:0] glyph_of(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = c_GLYPH_0;
            4'h1:    g = c_GLYPH_1;
            4'h2:    g = c_GLYPH_2;
            4'h3:    g = c_GLYPH_3;
            4'h4:    g = c_GLYPH_4;
            4'h5:    g = c_GLYPH_5;
            4'h6:    g = c_GLYPH_6;
            4'h7:    g = c_GLYPH_7;
            4'h8:    g = c_GLYPH_8;
            4'h9:    g = c_GLYPH_9;
            4'hA:    g = c_GLYPH_A;
            4'hB:    g = c_GLYPH_B;
            4'hC:    g = c_GLYPH_C;
            4'hD:    g = c_GLYPH_D;
            4'hE:    g = c_GLYPH_E;
            default: g = c_GLYPH_F;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_glyph_decode                                                    |
// | Maps one active-low 7-segment pattern back to its hex nibble.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_glyph_decode
    import segled_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_valid
);

    // Glyphs are unique, so at most one entry can match
    always_comb begin
        o_nibble = 4'h0;
        o_valid  = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (i_seg == glyph_of(4'(n))) begin
                o_nibble = 4'(n);
                o_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/segled_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segled_serial_rx                                                     |
// | Oversampling receiver for the 4-wire serial 7-segment link; latches  |
// | whole frames and decodes each segment byte back into a hex digit.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module segled_serial_rx
    import segled_pkg::*;
#(
    parameter int FRAME_BITS = c_FRAME_BITS,
    parameter int DIGITS     = FRAME_BITS / 8,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  seg_clk,
    input  logic                  seg_do,
    input  logic                  seg_pen,
    input  logic                  seg_clr,
    output logic [FRAME_BITS-1:0] seg_pattern,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [15:0]           frame_count
);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_do_sync;
    logic [1:0]            r_pen_sync;
    logic [1:0]            r_clr_sync;
    logic                  r_clk_d;
    logic                  r_pen_d;

    logic [c_ST_W-1:0]     r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [FRAME_BITS-1:0] r_seg_pattern;
    logic [4*DIGITS-1:0]   r_digits;
    logic [DIGITS-1:0]     r_digit_valid;
    logic                  r_frame_valid;
    logic                  r_frame_err;
    logic [15:0]           r_frame_count;

    logic                  w_clk_s;
    logic                  w_do_s;
    logic                  w_pen_s;
    logic                  w_clr_s;
    logic                  w_clk_rise;
    logic                  w_pen_rise;
    logic                  w_pen_fall;
    logic [4*DIGITS-1:0]   w_nibbles;
    logic [DIGITS-1:0]     w_valids;

    // pen synchronizer resets low so a reset mid-frame never produces a falling edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_clk_sync <= 2'b00;
            r_do_sync  <= 2'b00;
            r_pen_sync <= 2'b00;
            r_clr_sync <= 2'b11;
            r_clk_d    <= 1'b0;
            r_pen_d    <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], seg_clk};
            r_do_sync  <= {r_do_sync[0],  seg_do};
            r_pen_sync <= {r_pen_sync[0], seg_pen};
            r_clr_sync <= {r_clr_sync[0], seg_clr};
            r_clk_d    <= w_clk_s;
            r_pen_d    <= w_pen_s;
        end
    end

    assign w_clk_s    = r_clk_sync[1];
    assign w_do_s     = r_do_sync[1];
    assign w_pen_s    = r_pen_sync[1];
    assign w_clr_s    = r_clr_sync[1];
    assign w_clk_rise = w_clk_s & ~r_clk_d;
    assign w_pen_rise = w_pen_s & ~r_pen_d;
    assign w_pen_fall = ~w_pen_s & r_pen_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_seg_pattern <= '1;
            r_digits      <= '0;
            r_digit_valid <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else if (!w_clr_s) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_seg_pattern <= '1;
            r_digit_valid <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pen_fall) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    // A bit arriving with the pen rise is still counted
                    if (w_clk_rise) begin
                        r_shreg <= {r_shreg[FRAME_BITS-2:0], w_do_s};
                        if (r_cnt != CNT_W'(FRAME_BITS + 1))
                            r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_pen_rise)
                        r_state <= c_ST_LATCH;
                end
                c_ST_LATCH: begin
                    if (r_cnt == CNT_W'(FRAME_BITS)) begin
                        r_seg_pattern <= r_shreg;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= c_ST_DECODE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_digits      <= w_nibbles;
                    r_digit_valid <= w_valids;
                    r_frame_valid <= 1'b1;
                    r_state       <= c_ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        seg7_glyph_decode u_decode (
            .i_seg    (r_seg_pattern[8*gi +: 7]),
            .o_nibble (w_nibbles[4*gi +: 4]),
            .o_valid  (w_valids[gi])
        );
    end

    assign seg_pattern = r_seg_pattern;
    assign digits      = r_digits;
    assign digit_valid = r_digit_valid;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
